// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MD_WAIT  = 2'd1,
    MEM_WAIT = 2'd2
  } hz_state_t;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_W   = 2'b01;
  localparam logic [1:0] FWD_M   = 2'b10;

endpackage

// File: rtl/hazard_ctrl_fwd_unit.sv
// Forwarding select for one E-stage operand. M beats W; x0 never forwards.
module fwd_unit
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] rs,
  input  logic [REG_ADDR_W-1:0] rdM,
  input  logic                  regwriteM,
  input  logic [REG_ADDR_W-1:0] rdW,
  input  logic                  regwriteW,
  output logic [1:0]            fwd
);

  // priority select: youngest producer (M) wins
  always_comb begin
    fwd = FWD_REG;
    if (regwriteM && (rdM != '0) && (rdM == rs))      fwd = FWD_M;
    else if (regwriteW && (rdW != '0) && (rdW == rs)) fwd = FWD_W;
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use, branch flush, mul/div occupancy,
// D-cache miss wait, forwarding selects and stall/flush perf counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int REG_ADDR_W  = 5,
  parameter int DIV_LATENCY = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] rs1D,
  input  logic [REG_ADDR_W-1:0] rs2D,
  input  logic [REG_ADDR_W-1:0] rs1E,
  input  logic [REG_ADDR_W-1:0] rs2E,
  input  logic [REG_ADDR_W-1:0] rdE,
  input  logic [REG_ADDR_W-1:0] rdM,
  input  logic [REG_ADDR_W-1:0] rdW,
  input  logic                  loadE,
  input  logic                  regwriteM,
  input  logic                  regwriteW,
  input  logic                  pcsrcE,
  input  logic                  mdE,
  input  logic                  dmissM,
  input  logic                  dreadyM,
  output logic [1:0]            forwardAE,
  output logic [1:0]            forwardBE,
  output logic                  stallF,
  output logic                  stallD,
  output logic                  stallE,
  output logic                  stallM,
  output logic                  flushD,
  output logic                  flushE,
  output logic                  flushM,
  output logic                  flushW,
  output logic [WIDTH-1:0]      stall_cnt,
  output logic [WIDTH-1:0]      flush_cnt
);

  localparam int MDW = $clog2(DIV_LATENCY + 1);
  // first MD_WAIT count; RUN already spends one stall cycle on the op
  localparam logic [MDW-1:0] MD_LOAD = (DIV_LATENCY > 1) ? MDW'(DIV_LATENCY - 2) : '0;

  hz_state_t      state, state_nxt;
  logic [MDW-1:0] md_cnt, md_nxt;
  logic           lu;
  logic [1:0]     fa, fb;

  fwd_unit #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_a (
    .rs(rs1E), .rdM(rdM), .regwriteM(regwriteM), .rdW(rdW), .regwriteW(regwriteW), .fwd(fa)
  );
  fwd_unit #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_b (
    .rs(rs2E), .rdM(rdM), .regwriteM(regwriteM), .rdW(rdW), .regwriteW(regwriteW), .fwd(fb)
  );

  // selects are forced to register path while the pipeline is being cleared
  assign forwardAE = rst_n ? fa : FWD_REG;
  assign forwardBE = rst_n ? fb : FWD_REG;

  assign lu = loadE && (rdE != '0) && ((rdE == rs1D) || (rdE == rs2D));

  // stall/flush decode and next-state; no added latency
  always_comb begin
    stallF = 1'b0; stallD = 1'b0; stallE = 1'b0; stallM = 1'b0;
    flushD = 1'b0; flushE = 1'b0; flushM = 1'b0; flushW = 1'b0;
    state_nxt = state;
    md_nxt    = md_cnt;
    if (!rst_n) begin
      // pipeline registers have no reset of their own, so bubble everything
      flushD = 1'b1; flushE = 1'b1; flushM = 1'b1; flushW = 1'b1;
      state_nxt = RUN;
      md_nxt    = '0;
    end else begin
      unique case (state)
        RUN: begin
          if (dmissM) begin
            stallF = 1'b1; stallD = 1'b1; stallE = 1'b1; stallM = 1'b1; flushW = 1'b1;
            state_nxt = MEM_WAIT;
          end else if (mdE && (DIV_LATENCY > 1)) begin
            stallF = 1'b1; stallD = 1'b1; stallE = 1'b1; flushM = 1'b1;
            md_nxt    = MD_LOAD;
            state_nxt = MD_WAIT;
          end else if (pcsrcE) begin
            flushD = 1'b1; flushE = 1'b1;
          end else if (lu) begin
            stallF = 1'b1; stallD = 1'b1; flushE = 1'b1;
          end
        end
        MEM_WAIT: begin
          if (!dreadyM) begin
            stallF = 1'b1; stallD = 1'b1; stallE = 1'b1; stallM = 1'b1; flushW = 1'b1;
          end else begin
            // release cycle: M advances, held branch/load-use now act
            if (pcsrcE) begin
              flushD = 1'b1; flushE = 1'b1;
            end else if (lu) begin
              stallF = 1'b1; stallD = 1'b1; flushE = 1'b1;
            end
            state_nxt = RUN;
          end
        end
        MD_WAIT: begin
          // M only carries bubbles here, so a miss cannot be pending
          if (md_cnt != '0) begin
            stallF = 1'b1; stallD = 1'b1; stallE = 1'b1; flushM = 1'b1;
            md_nxt = md_cnt - MDW'(1);
          end else begin
            if (pcsrcE) begin
              flushD = 1'b1; flushE = 1'b1;
            end else if (lu) begin
              stallF = 1'b1; stallD = 1'b1; flushE = 1'b1;
            end
            state_nxt = RUN;
          end
        end
        default: state_nxt = RUN;
      endcase
    end
  end

  // state, mul/div countdown and perf counters
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= RUN;
      md_cnt    <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state  <= state_nxt;
      md_cnt <= md_nxt;
      if (stallF) stall_cnt <= stall_cnt + WIDTH'(1);
      if (flushD) flush_cnt <= flush_cnt + WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: driver pushes expected per-cycle outputs
// from a behavioural model, monitor pops and compares on the falling edge.
module tb_hazard_ctrl;
  localparam int WIDTH = 32;
  localparam int RAW   = 5;
  localparam int DL    = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic [RAW-1:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
  logic loadE, regwriteM, regwriteW, pcsrcE, mdE, dmissM, dreadyM;
  logic [1:0] forwardAE, forwardBE;
  logic stallF, stallD, stallE, stallM, flushD, flushE, flushM, flushW;
  logic [WIDTH-1:0] stall_cnt, flush_cnt;

  hazard_ctrl #(.WIDTH(WIDTH), .REG_ADDR_W(RAW), .DIV_LATENCY(DL)) dut (
    .clk(clk), .rst_n(rst_n),
    .rs1D(rs1D), .rs2D(rs2D), .rs1E(rs1E), .rs2E(rs2E),
    .rdE(rdE), .rdM(rdM), .rdW(rdW),
    .loadE(loadE), .regwriteM(regwriteM), .regwriteW(regwriteW),
    .pcsrcE(pcsrcE), .mdE(mdE), .dmissM(dmissM), .dreadyM(dreadyM),
    .forwardAE(forwardAE), .forwardBE(forwardBE),
    .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM),
    .flushD(flushD), .flushE(flushE), .flushM(flushM), .flushW(flushW),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  // st = {F,D,E,M}, fl = {D,E,M,W}
  typedef struct packed {
    logic [1:0]       fa, fb;
    logic [3:0]       st, fl;
    logic [WIDTH-1:0] sc, fc;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  // reference model: pending miss flag and remaining mul/div wait cycles
  bit               miss_pend = 0;
  int               md_left   = 0;
  logic [WIDTH-1:0] m_sc = '0, m_fc = '0;

  function automatic logic [1:0] fwd_of(logic [RAW-1:0] rs);
    if (regwriteM && rdM != 0 && rdM == rs) return 2'b10;
    if (regwriteW && rdW != 0 && rdW == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic void tail(inout exp_t e);
    bit lu;
    lu = loadE && rdE != 0 && (rdE == rs1D || rdE == rs2D);
    if (pcsrcE) e.fl = 4'b1100;
    else if (lu) begin e.st = 4'b1100; e.fl = 4'b0100; end
  endfunction

  // expected outputs for the inputs currently driven, then advance the model
  task automatic step();
    exp_t e;
    e = '0;
    e.sc = m_sc;
    e.fc = m_fc;
    if (!rst_n) begin
      e.fl = 4'b1111;
      miss_pend = 0; md_left = 0; m_sc = '0; m_fc = '0;
    end else begin
      e.fa = fwd_of(rs1E);
      e.fb = fwd_of(rs2E);
      if (miss_pend) begin
        if (!dreadyM) begin e.st = 4'b1111; e.fl = 4'b0001; end
        else begin tail(e); miss_pend = 0; end
      end else if (md_left > 0) begin
        if (md_left > 1) begin e.st = 4'b1110; e.fl = 4'b0010; end
        else tail(e);
        md_left--;
      end else if (dmissM) begin
        e.st = 4'b1111; e.fl = 4'b0001; miss_pend = 1;
      end else if (mdE && DL > 1) begin
        e.st = 4'b1110; e.fl = 4'b0010; md_left = DL - 1;
      end else tail(e);
      if (e.st[3]) m_sc++;
      if (e.fl[3]) m_fc++;
    end
    q.push_back(e);
  endtask

  task automatic go();
    step();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    rst_n = 1; rs1D = 0; rs2D = 0; rs1E = 0; rs2E = 0; rdE = 0; rdM = 0; rdW = 0;
    loadE = 0; regwriteM = 0; regwriteW = 0; pcsrcE = 0; mdE = 0; dmissM = 0; dreadyM = 0;
  endtask

  // monitor: compare whatever the DUT shows against the oldest expectation
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      if ({forwardAE, forwardBE} !== {e.fa, e.fb}) begin
        errors++;
        $display("FAIL fwd t=%0t got A=%b B=%b want A=%b B=%b", $time, forwardAE, forwardBE, e.fa, e.fb);
      end
      checks++;
      if ({stallF, stallD, stallE, stallM, flushD, flushE, flushM, flushW} !== {e.st, e.fl}) begin
        errors++;
        $display("FAIL ctrl t=%0t got st=%b fl=%b want st=%b fl=%b", $time,
                 {stallF, stallD, stallE, stallM}, {flushD, flushE, flushM, flushW}, e.st, e.fl);
      end
      checks++;
      if ({stall_cnt, flush_cnt} !== {e.sc, e.fc}) begin
        errors++;
        $display("FAIL cnt t=%0t got stall=%0d flush=%0d want stall=%0d flush=%0d", $time,
                 stall_cnt, flush_cnt, e.sc, e.fc);
      end
    end
  end

  initial begin
    idle();
    rst_n = 0;
    @(posedge clk); #1;
    // reset held two cycles
    rst_n = 0; go(); go();
    idle(); go();
    // forwarding priority and x0
    idle(); rs1E = 5; rs2E = 5; rdM = 5; regwriteM = 1; rdW = 5; regwriteW = 1; go();
    rdM = 0; go();
    rdW = 0; go();
    // load-use, then load-use masked by taken branch
    idle(); loadE = 1; rdE = 3; rs2D = 3; go();
    pcsrcE = 1; go();
    // single mul/div then idle
    idle(); mdE = 1; go();
    mdE = 1; go(); go(); mdE = 0; go(); go();
    // back-to-back mul/div
    mdE = 1; repeat (8) go();
    idle(); go();
    // miss with mul/div waiting behind it
    mdE = 1; dmissM = 1; repeat (5) go();
    dreadyM = 1; dmissM = 0; go();
    dreadyM = 0; repeat (4) go();
    mdE = 0; go();
    // reset during mul/div wait
    idle(); mdE = 1; go(); go();
    rst_n = 0; go();
    idle(); go(); go();
    // randomized traffic with occasional reset
    for (int i = 0; i < 1500; i++) begin
      rst_n     = ($urandom_range(0, 99) != 0);
      rs1D      = RAW'($urandom_range(0, 3));
      rs2D      = RAW'($urandom_range(0, 3));
      rs1E      = RAW'($urandom_range(0, 3));
      rs2E      = RAW'($urandom_range(0, 3));
      rdE       = RAW'($urandom_range(0, 3));
      rdM       = RAW'($urandom_range(0, 3));
      rdW       = RAW'($urandom_range(0, 3));
      loadE     = ($urandom_range(0, 2) == 0);
      regwriteM = $urandom_range(0, 1);
      regwriteW = $urandom_range(0, 1);
      pcsrcE    = ($urandom_range(0, 4) == 0);
      mdE       = ($urandom_range(0, 6) == 0);
      dmissM    = ($urandom_range(0, 9) == 0);
      dreadyM   = ($urandom_range(0, 2) == 0);
      go();
    end
    idle();
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    #1;
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain got %0d pending want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
